binary_to_rgb: RTL and testbench



---
 rtl/binary_to_rgb.sv | 79 +++++++
 tb/tb_binary_to_rgb.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/binary_to_rgb.sv
// binary_to_rgb: threshold 8-bit pixels to RGB, register with valid strobe, track raster, store in frame buffer
// Ports: clk, rst (async, active-high); binary_image_valid/binary_image_pixel in;
// rgb_pixel_r/g/b, rgb_pixel_valid, frame_done out; rd_row/rd_col in, rd_data out (combinational).
// Optional macro BINARY_TO_RGB_GRAY_EN: foreground outputs {p,p,p} instead of FG_COLOR.
module binary_to_rgb #(
    parameter int          WIDTH     = 10,
    parameter int          HEIGHT    = 10,
    parameter logic [7:0]  THRESHOLD = 8'd128,
    parameter logic [23:0] FG_COLOR  = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR  = 24'h000000,
    localparam int         RW        = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
    localparam int         CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          binary_image_valid,
    input  logic [7:0]    binary_image_pixel,
    output logic [7:0]    rgb_pixel_r,
    output logic [7:0]    rgb_pixel_g,
    output logic [7:0]    rgb_pixel_b,
    output logic          rgb_pixel_valid,
    output logic          frame_done,
    input  logic [RW-1:0] rd_row,
    input  logic [CW-1:0] rd_col,
    output logic [23:0]   rd_data
);
    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [23:0]   mem_q [DEPTH];
    logic [23:0]   rgb_q, color_d, fg_color;
    logic          valid_q, done_q;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          last_col, last_row;
    logic [AW-1:0] wr_addr, rd_addr;

    always_comb begin
`ifdef BINARY_TO_RGB_GRAY_EN
        fg_color = {3{binary_image_pixel}};
`else
        fg_color = FG_COLOR;
`endif
        color_d  = (binary_image_pixel >= THRESHOLD) ? fg_color : BG_COLOR;
        last_col = col_q == CW'(WIDTH - 1);
        last_row = row_q == RW'(HEIGHT - 1);
        col_d    = binary_image_valid ? (last_col ? '0 : col_q + CW'(1)) : col_q;
        row_d    = (binary_image_valid && last_col) ? (last_row ? '0 : row_q + RW'(1)) : row_q;
        wr_addr  = AW'(int'(row_q) * WIDTH + int'(col_q));
        rd_addr  = AW'(int'(rd_row) * WIDTH + int'(rd_col));
        rd_data  = (int'(rd_row) < HEIGHT && int'(rd_col) < WIDTH) ? mem_q[rd_addr] : 24'h000000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            valid_q <= binary_image_valid;
            done_q  <= binary_image_valid && last_col && last_row;
            row_q   <= row_d;
            col_q   <= col_d;
            if (binary_image_valid) begin
                rgb_q          <= color_d;
                mem_q[wr_addr] <= color_d;
            end
        end
    end

    assign rgb_pixel_r     = rgb_q[23:16];
    assign rgb_pixel_g     = rgb_q[15:8];
    assign rgb_pixel_b     = rgb_q[7:0];
    assign rgb_pixel_valid = valid_q;
    assign frame_done      = done_q;
endmodule

// File: tb/tb_binary_to_rgb.sv
// tb_binary_to_rgb: directed self-checking bench for binary_to_rgb
module tb_binary_to_rgb;
    logic        clk = 1'b0;
    logic        rst;
    logic        binary_image_valid;
    logic [7:0]  binary_image_pixel;
    logic [7:0]  rgb_pixel_r, rgb_pixel_g, rgb_pixel_b;
    logic        rgb_pixel_valid, frame_done;
    logic [3:0]  rd_row, rd_col;
    logic [23:0] rd_data;
    int errors = 0;
    int checks = 0;

    binary_to_rgb dut (
        .clk(clk), .rst(rst),
        .binary_image_valid(binary_image_valid), .binary_image_pixel(binary_image_pixel),
        .rgb_pixel_r(rgb_pixel_r), .rgb_pixel_g(rgb_pixel_g), .rgb_pixel_b(rgb_pixel_b),
        .rgb_pixel_valid(rgb_pixel_valid), .frame_done(frame_done),
        .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] fg(input logic [7:0] p);
`ifdef BINARY_TO_RGB_GRAY_EN
        return {3{p}};
`else
        return 24'hFFFFFF;
`endif
    endfunction

    task automatic send(input logic v, input logic [7:0] p);
        binary_image_valid = v;
        binary_image_pixel = p;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        binary_image_valid = 1'b0;
        binary_image_pixel = 8'h00;
        rd_row = 4'd0;
        rd_col = 4'd0;
        #1;
        checks++;
        if ({rgb_pixel_r, rgb_pixel_g, rgb_pixel_b, rgb_pixel_valid, frame_done} !== 26'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", {rgb_pixel_r, rgb_pixel_g, rgb_pixel_b, rgb_pixel_valid, frame_done});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_row = 4'd9;
        rd_col = 4'd9;
        #1;
        checks++;
        if (rd_data !== 24'h0) begin
            errors++;
            $display("FAIL reset_rd_data got %h exp 000000", rd_data);
        end
    endtask

    task automatic test_threshold();
        send(1'b1, 8'h7F);
        checks++;
        if ({rgb_pixel_valid, rgb_pixel_r, rgb_pixel_g, rgb_pixel_b} !== {1'b1, 24'h000000}) begin
            errors++;
            $display("FAIL thr_7F got %h exp %h", {rgb_pixel_valid, rgb_pixel_r, rgb_pixel_g, rgb_pixel_b}, {1'b1, 24'h000000});
        end
        send(1'b1, 8'h80);
        checks++;
        if ({rgb_pixel_valid, rgb_pixel_r, rgb_pixel_g, rgb_pixel_b} !== {1'b1, fg(8'h80)}) begin
            errors++;
            $display("FAIL thr_80 got %h exp %h", {rgb_pixel_valid, rgb_pixel_r, rgb_pixel_g, rgb_pixel_b}, {1'b1, fg(8'h80)});
        end
        send(1'b0, 8'h00);
        checks++;
        if ({rgb_pixel_valid, rgb_pixel_r, rgb_pixel_g, rgb_pixel_b} !== {1'b0, fg(8'h80)}) begin
            errors++;
            $display("FAIL thr_idle got %h exp %h", {rgb_pixel_valid, rgb_pixel_r, rgb_pixel_g, rgb_pixel_b}, {1'b0, fg(8'h80)});
        end
    endtask

    task automatic test_gapped();
        send(1'b1, 8'hFF);
        checks++;
        if ({rgb_pixel_valid, rgb_pixel_r, rgb_pixel_g, rgb_pixel_b} !== {1'b1, fg(8'hFF)}) begin
            errors++;
            $display("FAIL gap_ff got %h exp %h", {rgb_pixel_valid, rgb_pixel_r, rgb_pixel_g, rgb_pixel_b}, {1'b1, fg(8'hFF)});
        end
        send(1'b0, 8'h00);
        checks++;
        if ({rgb_pixel_valid, rgb_pixel_r, rgb_pixel_g, rgb_pixel_b} !== {1'b0, fg(8'hFF)}) begin
            errors++;
            $display("FAIL gap_hold got %h exp %h", {rgb_pixel_valid, rgb_pixel_r, rgb_pixel_g, rgb_pixel_b}, {1'b0, fg(8'hFF)});
        end
        send(1'b1, 8'h00);
        checks++;
        if ({rgb_pixel_valid, rgb_pixel_r, rgb_pixel_g, rgb_pixel_b} !== {1'b1, 24'h000000}) begin
            errors++;
            $display("FAIL gap_00 got %h exp %h", {rgb_pixel_valid, rgb_pixel_r, rgb_pixel_g, rgb_pixel_b}, {1'b1, 24'h000000});
        end
    endtask

    task automatic test_full_frame();
        do_reset();
        for (int k = 0; k < 100; k++) begin
            send(1'b1, k[0] ? 8'hFF : 8'h00);
            checks++;
            if ({frame_done, rgb_pixel_valid, rgb_pixel_r, rgb_pixel_g, rgb_pixel_b} !== {k == 99, 1'b1, k[0] ? fg(8'hFF) : 24'h000000}) begin
                errors++;
                $display("FAIL frame_px%0d got %h exp %h", k, {frame_done, rgb_pixel_valid, rgb_pixel_r, rgb_pixel_g, rgb_pixel_b}, {k == 99, 1'b1, k[0] ? fg(8'hFF) : 24'h000000});
            end
        end
        send(1'b0, 8'h00);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_clear got %b exp 0", frame_done);
        end
        rd_row = 4'd3;
        rd_col = 4'd5;
        #1;
        checks++;
        if (rd_data !== fg(8'hFF)) begin
            errors++;
            $display("FAIL rd_3_5 got %h exp %h", rd_data, fg(8'hFF));
        end
        rd_row = 4'd9;
        rd_col = 4'd8;
        #1;
        checks++;
        if (rd_data !== 24'h000000) begin
            errors++;
            $display("FAIL rd_9_8 got %h exp 000000", rd_data);
        end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 5; k++) begin
            send(1'b1, 8'hFF);
            checks++;
            if (frame_done !== 1'b0) begin
                errors++;
                $display("FAIL wrap_done%0d got %b exp 0", k, frame_done);
            end
        end
        rd_row = 4'd0;
        for (int c = 0; c < 5; c++) begin
            rd_col = 4'(c);
            #1;
            checks++;
            if (rd_data !== fg(8'hFF)) begin
                errors++;
                $display("FAIL wrap_rd_0_%0d got %h exp %h", c, rd_data, fg(8'hFF));
            end
        end
        rd_col = 4'd6;
        #1;
        checks++;
        if (rd_data !== 24'h000000) begin
            errors++;
            $display("FAIL wrap_rd_0_6 got %h exp 000000", rd_data);
        end
        rd_row = 4'd10;
        rd_col = 4'd1;
        #1;
        checks++;
        if (rd_data !== 24'h000000) begin
            errors++;
            $display("FAIL rd_oob_row got %h exp 000000", rd_data);
        end
        rd_row = 4'd0;
        rd_col = 4'd12;
        #1;
        checks++;
        if (rd_data !== 24'h000000) begin
            errors++;
            $display("FAIL rd_oob_col got %h exp 000000", rd_data);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int k = 0; k < 37; k++) send(1'b1, 8'hFF);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({rgb_pixel_r, rgb_pixel_g, rgb_pixel_b, rgb_pixel_valid, frame_done} !== 26'h0) begin
            errors++;
            $display("FAIL midrst_outputs got %h exp 0", {rgb_pixel_r, rgb_pixel_g, rgb_pixel_b, rgb_pixel_valid, frame_done});
        end
        rd_row = 4'd3;
        rd_col = 4'd6;
        #1;
        checks++;
        if (rd_data !== 24'h000000) begin
            errors++;
            $display("FAIL midrst_rd_3_6 got %h exp 000000", rd_data);
        end
        rst = 1'b0;
        rd_row = 4'd0;
        rd_col = 4'd0;
        binary_image_valid = 1'b1;
        binary_image_pixel = 8'hFF;
        #1;
        checks++;
        if (rd_data !== 24'h000000) begin
            errors++;
            $display("FAIL rd_before_write got %h exp 000000", rd_data);
        end
        @(posedge clk);
        #1;
        binary_image_valid = 1'b0;
        checks++;
        if (rd_data !== fg(8'hFF)) begin
            errors++;
            $display("FAIL midrst_rd_0_0 got %h exp %h", rd_data, fg(8'hFF));
        end
        rd_col = 4'd1;
        #1;
        checks++;
        if (rd_data !== 24'h000000) begin
            errors++;
            $display("FAIL midrst_rd_0_1 got %h exp 000000", rd_data);
        end
    endtask

    task automatic test_gray();
        send(1'b1, 8'hC3);
        checks++;
        if ({rgb_pixel_r, rgb_pixel_g, rgb_pixel_b} !== fg(8'hC3)) begin
            errors++;
            $display("FAIL gray_c3 got %h exp %h", {rgb_pixel_r, rgb_pixel_g, rgb_pixel_b}, fg(8'hC3));
        end
        send(1'b1, 8'h10);
        checks++;
        if ({rgb_pixel_r, rgb_pixel_g, rgb_pixel_b} !== 24'h000000) begin
            errors++;
            $display("FAIL gray_10 got %h exp 000000", {rgb_pixel_r, rgb_pixel_g, rgb_pixel_b});
        end
        rd_row = 4'd0;
        rd_col = 4'd1;
        #1;
        checks++;
        if (rd_data !== fg(8'hC3)) begin
            errors++;
            $display("FAIL gray_rd_0_1 got %h exp %h", rd_data, fg(8'hC3));
        end
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_gapped();
        test_full_frame();
        test_wrap();
        test_mid_reset();
        test_gray();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
